// File: rtl/oled_cmd_arbiter_if.sv
// Command-sharing bus between NREQ requesters, the arbiter and OLEDCtrl.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface oled_cmd_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [3*NREQ-1:0] req_op;
   logic [9*NREQ-1:0] req_addr;
   logic [8*NREQ-1:0] req_ascii;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic              err;
   logic              busy;
   logic              write_start;
   logic              update_start;
   logic              disp_on_start;
   logic              disp_off_start;
   logic              toggle_disp_start;
   logic              update_clear;
   logic [8:0]        write_base_addr;
   logic [7:0]        write_ascii_data;
   logic              write_ready;
   logic              update_ready;
   logic              disp_on_ready;
   logic              disp_off_ready;
   logic              toggle_disp_ready;

   modport slave (
      input  req, req_op, req_addr, req_ascii,
      input  write_ready, update_ready, disp_on_ready, disp_off_ready, toggle_disp_ready,
      output grant, done, err, busy,
      output write_start, update_start, disp_on_start, disp_off_start, toggle_disp_start,
      output update_clear, write_base_addr, write_ascii_data
   );

   modport master (
      output req, req_op, req_addr, req_ascii,
      output write_ready, update_ready, disp_on_ready, disp_off_ready, toggle_disp_ready,
      input  grant, done, err, busy,
      input  write_start, update_start, disp_on_start, disp_off_start, toggle_disp_start,
      input  update_clear, write_base_addr, write_ascii_data
   );
endinterface

// File: rtl/oled_cmd_arbiter.sv
// Round-robin arbiter sharing the OLEDCtrl command port; tracks the ready handshake per command.
// Define OLED_ARB_PRIO0_EN to give requester 0 fixed top priority over the round-robin rest.
module oled_cmd_arbiter #(
   parameter int NREQ = 4,
   parameter int TO_W = 20
) (
   input logic               clk,
   input logic               rst,
   oled_cmd_arbiter_if.slave bus
);
   localparam int IW = $clog2(NREQ);
`ifdef OLED_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   localparam logic [2:0] OP_WRITE      = 3'd0;
   localparam logic [2:0] OP_UPDATE     = 3'd1;
   localparam logic [2:0] OP_UPDATE_CLR = 3'd2;
   localparam logic [2:0] OP_DISP_ON    = 3'd3;
   localparam logic [2:0] OP_DISP_OFF   = 3'd4;
   localparam logic [2:0] OP_TOGGLE     = 3'd5;

   typedef enum logic [2:0] {S_IDLE, S_WAITRDY, S_ISSUE, S_ACCEPT, S_RUN, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   ptr, ptr_nxt, pick, idx_q;
   logic            any_req, load;
   logic [2:0]      op_q, op_pick;
   logic [8:0]      addr_q, addr_pick;
   logic [7:0]      ascii_q, ascii_pick;
   logic            clr_q, err_q, err_nxt;
   logic [TO_W-1:0] cnt_q, cnt_nxt, cnt_inc;
   logic            rdy_sel, illegal, timeout, granted, issue;
   logic [NREQ-1:0] onehot;

   function automatic logic [IW-1:0] wrap_idx(input int v);
      return IW'(v % NREQ);
   endfunction

   // Search upward from the pointer; under priority mode requester 0 is taken out of the ring.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the block infers a latch.
      any_req = 1'b0;
      pick    = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any_req && bus.req[wrap_idx(int'(ptr) + k)] &&
             !(PRIO0 && wrap_idx(int'(ptr) + k) == '0)) begin
            any_req = 1'b1;
            pick    = wrap_idx(int'(ptr) + k);
         end
      end
      if (PRIO0 && bus.req[0]) begin
         any_req = 1'b1;
         pick    = '0;
      end
   end

   always_comb begin
      ptr_nxt = wrap_idx(int'(pick) + 1);
      if (PRIO0) begin
         if (pick == '0)         ptr_nxt = ptr;
         else if (ptr_nxt == '0) ptr_nxt = IW'(1);
      end
   end

   always_comb begin
      op_pick    = '0;
      addr_pick  = '0;
      ascii_pick = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick == IW'(i)) begin
            op_pick    = bus.req_op[3*i +: 3];
            addr_pick  = bus.req_addr[9*i +: 9];
            ascii_pick = bus.req_ascii[8*i +: 8];
         end
      end
   end

   always_comb begin
      case (op_q)
         OP_WRITE:                 rdy_sel = bus.write_ready;
         OP_UPDATE, OP_UPDATE_CLR: rdy_sel = bus.update_ready;
         OP_DISP_ON:               rdy_sel = bus.disp_on_ready;
         OP_DISP_OFF:              rdy_sel = bus.disp_off_ready;
         OP_TOGGLE:                rdy_sel = bus.toggle_disp_ready;
         default:                  rdy_sel = 1'b0;
      endcase
   end

   assign illegal = (op_q > OP_TOGGLE);
   assign cnt_inc = cnt_q + TO_W'(1);
   assign timeout = &cnt_inc;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_q;
      err_nxt   = err_q;
      load      = 1'b0;
      case (state)
         S_IDLE: if (any_req) begin
            load      = 1'b1;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
            state_nxt = S_WAITRDY;
         end
         S_WAITRDY: begin
            if (illegal) begin
               err_nxt   = 1'b1;
               state_nxt = S_DONE;
            end else if (rdy_sel) begin
               cnt_nxt   = '0;
               state_nxt = S_ISSUE;
            end else begin
               cnt_nxt = cnt_inc;
               if (timeout) begin
                  err_nxt   = 1'b1;
                  state_nxt = S_DONE;
               end
            end
         end
         S_ISSUE: state_nxt = S_ACCEPT;
         S_ACCEPT: begin
            if (!rdy_sel) begin
               cnt_nxt   = '0;
               state_nxt = S_RUN;
            end else begin
               cnt_nxt = cnt_inc;
               if (timeout) begin
                  err_nxt   = 1'b1;
                  state_nxt = S_DONE;
               end
            end
         end
         S_RUN: if (rdy_sel) state_nxt = S_DONE;
         S_DONE: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state   <= S_IDLE;
         ptr     <= '0;
         idx_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         ascii_q <= '0;
         clr_q   <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt_q <= cnt_nxt;
         err_q <= err_nxt;
         if (load) begin
            idx_q   <= pick;
            op_q    <= op_pick;
            addr_q  <= addr_pick;
            ascii_q <= ascii_pick;
            clr_q   <= (op_pick == OP_UPDATE_CLR);
            ptr     <= ptr_nxt;
         end
      end
   end

   assign onehot  = NREQ'(1) << idx_q;
   assign granted = (state == S_WAITRDY) || (state == S_ISSUE) ||
                    (state == S_ACCEPT)  || (state == S_RUN);
   assign issue   = (state == S_ISSUE);

   assign bus.grant             = granted ? onehot : '0;
   assign bus.done              = (state == S_DONE) ? onehot : '0;
   assign bus.err               = (state == S_DONE) && err_q;
   assign bus.busy              = (state != S_IDLE);
   assign bus.write_start       = issue && (op_q == OP_WRITE);
   assign bus.update_start      = issue && ((op_q == OP_UPDATE) || (op_q == OP_UPDATE_CLR));
   assign bus.disp_on_start     = issue && (op_q == OP_DISP_ON);
   assign bus.disp_off_start    = issue && (op_q == OP_DISP_OFF);
   assign bus.toggle_disp_start = issue && (op_q == OP_TOGGLE);
   assign bus.update_clear      = clr_q;
   assign bus.write_base_addr   = addr_q;
   assign bus.write_ascii_data  = ascii_q;
endmodule

// File: doc/oled_cmd_arbiter.md
Name: oled_cmd_arbiter

Overview:
- Shares the single OLEDCtrl command interface between NREQ independent requesters, for example a text-fill sequencer, a button handler and a status updater.
- Grants one requester at a time, round robin, and latches that requester's command and data.
- Issues the matching one-cycle start pulse, then tracks the OLEDCtrl ready handshake until the command completes.
- Returns a done/err pulse to the granted requester. Sits between the top-level control logic and OLEDCtrl.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TO_W, 20, width of the timeout counter; the timeout fires at 2^TO_W-1 cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; held high until that requester's done pulse
- req_op  in  3*NREQ  opcode per requester, slice i = [3i+2:3i]
- req_addr  in  9*NREQ  write_base_addr per requester
- req_ascii  in  8*NREQ  ascii per requester
- grant  out  NREQ  one-hot; high from grant until done
- done  out  NREQ  one-cycle completion pulse
- err  out  1  valid only with a done pulse; 1 = illegal opcode or timeout
- busy  out  1  high in any state except IDLE
- write_start, update_start, disp_on_start, disp_off_start, toggle_disp_start  out  1 each  start pulses to OLEDCtrl
- update_clear  out  1  clear flag to OLEDCtrl
- write_base_addr  out  9  to OLEDCtrl
- write_ascii_data  out  8  to OLEDCtrl
- write_ready, update_ready, disp_on_ready, disp_off_ready, toggle_disp_ready  in  1 each  from OLEDCtrl

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset values:
  - all outputs 0;
  - round-robin pointer = 0;
  - timeout counter = 0;
  - state = IDLE.
- Opcodes:
  - 0 WRITE
  - 1 UPDATE (update_clear=0)
  - 2 UPDATE_CLR (update_clear=1)
  - 3 DISP_ON
  - 4 DISP_OFF
  - 5 TOGGLE
  - 6, 7 illegal
- The selected ready (rdy_sel) is the ready input matching the latched opcode.

State machine:
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from the pointer, wrapping.
  - Assert grant[i]; latch op, addr, ascii and update_clear; go to WAITRDY next cycle.
  - Pointer = i+1 mod NREQ, updated at grant.
- WAITRDY:
  - Illegal op: go to DONE with err=1.
  - rdy_sel=1: go to ISSUE, counter cleared.
  - Otherwise the counter increments. At all-ones go to DONE with err=1 (this covers, for example, DISP_ON while the display is already on).
- ISSUE:
  - Exactly one cycle: the matching start output = 1; go to ACCEPT.
  - write_base_addr, write_ascii_data and update_clear hold their latched values from grant until the next grant.
- ACCEPT:
  - Wait for rdy_sel=0, then go to RUN with the counter cleared.
  - Timeout as in WAITRDY gives DONE with err=1.
- RUN:
  - Wait for rdy_sel=1, then go to DONE with err=0.
  - No timeout: updates take milliseconds.
- DONE:
  - done[i]=1 and err valid for one cycle; grant cleared in the same cycle; go to IDLE.
  - A new grant can occur at the earliest on the cycle after DONE.

Boundary conditions and latency:
- Latency from req to start pulse is 3 cycles when rdy_sel is already high: grant, WAITRDY, ISSUE.
- Requesters sampled simultaneously are served in round-robin order. A requester cannot win twice in a row while another requests.
- Requester behaviour while granted:
  - Dropping req while granted is ignored; the command completes and done still pulses.
  - req still high after done is treated as a new request.
- Changes to req_op, req_addr or req_ascii after grant have no effect.
- rst mid-command: all start outputs drop immediately and no done is produced. OLEDCtrl is not reset by this block.

Optional Feature:
- Macro: OLED_ARB_PRIO0_EN.
- Defined: requester 0 has fixed highest priority and wins whenever its req is set in IDLE. The remaining requesters are round robin among themselves, and the pointer skips 0.
- Undefined: pure round robin across all NREQ requesters.

Test Plan:
- Single WRITE on req0 (addr 0x008, ascii 0x41), write_ready=1, model drops ready 2 cycles after start and raises it 10 cycles later -> write_start high for exactly 1 cycle, 3 cycles after req; write_base_addr=0x008; write_ascii_data=0x41; done[0] pulses with err=0.
- req0 and req2 both high from reset, both UPDATE -> req0 served first, then req2. With req0 re-requesting, the order is 0, 2, 0, 2. No overlapping start pulses.
- req1 with op=6 -> done[1] pulses with err=1 two cycles after grant; no start pulse issued.
- DISP_ON with disp_on_ready held 0, TO_W=4 -> err=1 after 15 WAITRDY cycles; no start pulse.
- rst asserted during RUN of an UPDATE_CLR -> next cycle all outputs 0, busy=0, no done pulse.
- With OLED_ARB_PRIO0_EN defined: req1 and req0 pending continuously -> req0 granted every arbitration; req1 granted only when req0 is low.
